// File: rtl/lsu_pkg.sv
// lsu_pkg -- opcodes, FSM state type and opcode classification for the LSU. Rev 1.0
`default_nettype none
package lsu_pkg;

  localparam logic [5:0] OP_LWZ = 6'd32;
  localparam logic [5:0] OP_LBZ = 6'd34;
  localparam logic [5:0] OP_STW = 6'd36;
  localparam logic [5:0] OP_STB = 6'd38;
  localparam logic [5:0] OP_LHZ = 6'd40;
  localparam logic [5:0] OP_LHA = 6'd42;
  localparam logic [5:0] OP_STH = 6'd44;
  localparam logic [5:0] OP_LD  = 6'd58;
  localparam logic [5:0] OP_STD = 6'd62;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_STORE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LWZ) || (op == OP_LBZ) || (op == OP_LHZ) ||
           (op == OP_LHA) || (op == OP_LD);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == OP_STW) || (op == OP_STB) || (op == OP_STH) || (op == OP_STD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_fmt.sv
// lsu_load_fmt -- formats raw ReadData by load opcode; LSU_SIGN_EXT_EN makes lha sign-extend. Rev 1.0
`default_nettype none
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [63:0] rdata,
  output logic [63:0] data
);

  always_comb begin
    data = 64'd0;
    case (opcode)
      OP_LBZ: data = {56'd0, rdata[7:0]};
      OP_LHZ: data = {48'd0, rdata[15:0]};
`ifdef LSU_SIGN_EXT_EN
      OP_LHA: data = {{48{rdata[15]}}, rdata[15:0]};
`else
      OP_LHA: data = {48'd0, rdata[15:0]};
`endif
      OP_LWZ: data = {32'd0, rdata[31:0]};
      OP_LD:  data = rdata;
      default: data = 64'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
// lsu_mem_master -- sequences one load/store per request against a fixed-latency data memory.
// Build option LSU_SIGN_EXT_EN (see lsu_load_fmt) selects lha sign extension. Rev 1.0
`default_nettype none
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_illegal,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [63:0] mem_address,
  output logic [63:0] mem_wdata,
  output logic [5:0]  mem_opcode,
  input  logic [63:0] mem_rdata
);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic        accept;
  logic        req_is_load;
  logic        req_is_store;
  logic [63:0] fmt_data;

  assign accept       = req_valid && (state == S_IDLE);
  assign req_is_load  = is_load(req_opcode);
  assign req_is_store = is_store(req_opcode);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_is_load)       state_next = S_LOAD;
          else if (req_is_store) state_next = S_STORE;
          else                   state_next = S_RESP;
        end
      end
      S_LOAD: begin
        MemRead = 1'b1;
        if (cnt <= 4'd1) state_next = S_RESP;
      end
      S_STORE: begin
        // A reset arriving during the store cycle must keep the write from landing.
        MemWrite   = !rst;
        state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= 4'd0;
      resp_data    <= 64'd0;
      resp_illegal <= 1'b0;
      mem_address  <= 64'd0;
      mem_wdata    <= 64'd0;
      mem_opcode   <= 6'd0;
    end else begin
      if (accept) begin
        if (req_is_load || req_is_store) begin
          mem_address <= req_addr;
          mem_wdata   <= req_wdata;
          mem_opcode  <= req_opcode;
        end else begin
          resp_data    <= 64'd0;
          resp_illegal <= 1'b1;
        end
        if (req_is_load) cnt <= 4'(MEM_LAT);
      end
      if (state == S_LOAD) begin
        cnt <= cnt - 4'd1;
        if (cnt <= 4'd1) begin
          resp_data    <= fmt_data;
          resp_illegal <= 1'b0;
        end
      end
      if (state == S_STORE) begin
        resp_data    <= 64'd0;
        resp_illegal <= 1'b0;
      end
    end
  end

  lsu_load_fmt u_load_fmt (
    .opcode (mem_opcode),
    .rdata  (mem_rdata),
    .data   (fmt_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master -- directed checks on three instances (MEM_LAT = 1, 3, 2). Rev 1.0
`default_nettype none
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [3];
  logic [5:0]  req_opcode;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] mem_rdata;

  logic        req_ready    [3];
  logic        resp_valid   [3];
  logic [63:0] resp_data    [3];
  logic        resp_illegal [3];
  logic        mem_read     [3];
  logic        mem_write    [3];
  logic [63:0] mem_address  [3];
  logic [63:0] mem_wdata    [3];
  logic [5:0]  mem_opcode   [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
      lsu_mem_master #(.MEM_LAT(LAT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid[g]),
        .req_ready    (req_ready[g]),
        .req_opcode   (req_opcode),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid[g]),
        .resp_data    (resp_data[g]),
        .resp_illegal (resp_illegal[g]),
        .MemRead      (mem_read[g]),
        .MemWrite     (mem_write[g]),
        .mem_address  (mem_address[g]),
        .mem_wdata    (mem_wdata[g]),
        .mem_opcode   (mem_opcode[g]),
        .mem_rdata    (mem_rdata)
      );
    end
  endgenerate

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int u = 0; u < 3; u++) begin
      checks++; if (req_ready[u] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", u, req_ready[u]); end
      checks++; if (resp_valid[u] !== 1'b0 || resp_illegal[u] !== 1'b0) begin errors++; $display("FAIL reset_resp[%0d]: got v=%b i=%b want 0/0", u, resp_valid[u], resp_illegal[u]); end
      checks++; if (mem_read[u] !== 1'b0 || mem_write[u] !== 1'b0) begin errors++; $display("FAIL reset_strobes[%0d]: got r=%b w=%b want 0/0", u, mem_read[u], mem_write[u]); end
      checks++; if (resp_data[u] !== 64'd0 || mem_address[u] !== 64'd0 || mem_wdata[u] !== 64'd0 || mem_opcode[u] !== 6'd0) begin errors++; $display("FAIL reset_regs[%0d]: got data=%h addr=%h wd=%h op=%0d want zeros", u, resp_data[u], mem_address[u], mem_wdata[u], mem_opcode[u]); end
    end
  endtask

  task automatic test_lbz;
    req_valid[0] = 1'b1; req_opcode = 6'd34; req_addr = 64'd5; req_wdata = 64'd0;
    mem_rdata = 64'hAAAA_AAAA_AAAA_00F3;
    tick();
    req_valid[0] = 1'b0;
    checks++; if (mem_read[0] !== 1'b1 || mem_address[0] !== 64'd5 || mem_opcode[0] !== 6'd34) begin errors++; $display("FAIL lbz_c1_read: got r=%b addr=%h op=%0d want 1/5/34", mem_read[0], mem_address[0], mem_opcode[0]); end
    checks++; if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin errors++; $display("FAIL lbz_c1_ctl: got rdy=%b v=%b want 0/0", req_ready[0], resp_valid[0]); end
    tick();
    checks++; if (mem_read[0] !== 1'b0 || resp_valid[0] !== 1'b1) begin errors++; $display("FAIL lbz_c2: got r=%b v=%b want 0/1", mem_read[0], resp_valid[0]); end
    checks++; if (resp_data[0] !== 64'h0000_0000_0000_00F3 || resp_illegal[0] !== 1'b0) begin errors++; $display("FAIL lbz_data: got %h ill=%b want 00000000000000f3/0", resp_data[0], resp_illegal[0]); end
    tick();
    checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || resp_data[0] !== 64'h0000_0000_0000_00F3) begin errors++; $display("FAIL lbz_c3_hold: got v=%b rdy=%b data=%h", resp_valid[0], req_ready[0], resp_data[0]); end
  endtask

  task automatic test_store;
    req_valid[0] = 1'b1; req_opcode = 6'd36; req_addr = 64'd9; req_wdata = 64'h1122_3344_5566_7788;
    tick();
    req_valid[0] = 1'b0;
    checks++; if (mem_write[0] !== 1'b1 || mem_read[0] !== 1'b0) begin errors++; $display("FAIL stw_c1_strobes: got w=%b r=%b want 1/0", mem_write[0], mem_read[0]); end
    checks++; if (mem_opcode[0] !== 6'd36 || mem_address[0] !== 64'd9 || mem_wdata[0] !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL stw_c1_bus: got op=%0d addr=%h wd=%h", mem_opcode[0], mem_address[0], mem_wdata[0]); end
    tick();
    checks++; if (mem_write[0] !== 1'b0 || resp_valid[0] !== 1'b1 || resp_data[0] !== 64'd0) begin errors++; $display("FAIL stw_c2: got w=%b v=%b data=%h want 0/1/0", mem_write[0], resp_valid[0], resp_data[0]); end
    tick();
  endtask

  task automatic test_lha;
    logic [63:0] exp;
`ifdef LSU_SIGN_EXT_EN
    exp = 64'hFFFF_FFFF_FFFF_8001;
`else
    exp = 64'h0000_0000_0000_8001;
`endif
    req_valid[0] = 1'b1; req_opcode = 6'd42; req_addr = 64'd3;
    mem_rdata = 64'h1234_5678_9ABC_8001;
    tick();
    req_valid[0] = 1'b0;
    tick();
    checks++; if (resp_valid[0] !== 1'b1 || resp_data[0] !== exp) begin errors++; $display("FAIL lha_data: got v=%b data=%h want 1/%h", resp_valid[0], resp_data[0], exp); end
    tick();
  endtask

  task automatic test_illegal;
    req_valid[0] = 1'b1; req_opcode = 6'd31; req_addr = 64'd100;
    tick();
    req_valid[0] = 1'b0;
    checks++; if (mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0) begin errors++; $display("FAIL ill_strobes: got r=%b w=%b want 0/0", mem_read[0], mem_write[0]); end
    checks++; if (resp_valid[0] !== 1'b1 || resp_illegal[0] !== 1'b1 || resp_data[0] !== 64'd0) begin errors++; $display("FAIL ill_resp: got v=%b i=%b data=%h want 1/1/0", resp_valid[0], resp_illegal[0], resp_data[0]); end
    checks++; if (mem_opcode[0] !== 6'd42 || mem_address[0] !== 64'd3) begin errors++; $display("FAIL ill_bus_hold: got op=%0d addr=%h want 42/3", mem_opcode[0], mem_address[0]); end
    tick();
    checks++; if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0 || resp_illegal[0] !== 1'b1) begin errors++; $display("FAIL ill_c2: got rdy=%b v=%b i=%b want 1/0/1", req_ready[0], resp_valid[0], resp_illegal[0]); end
  endtask

  task automatic test_load_fmt;
    logic [5:0]  ops  [4];
    logic [63:0] exps [4];
    ops  = '{6'd40, 6'd32, 6'd58, 6'd34};
    exps = '{64'h0000_0000_0000_3210, 64'h0000_0000_7654_3210,
             64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_0010};
    mem_rdata = 64'hFEDC_BA98_7654_3210;
    for (int k = 0; k < 4; k++) begin
      req_valid[0] = 1'b1; req_opcode = ops[k]; req_addr = 64'(k * 8);
      tick();
      req_valid[0] = 1'b0;
      tick();
      checks++; if (resp_valid[0] !== 1'b1 || resp_illegal[0] !== 1'b0 || resp_data[0] !== exps[k]) begin errors++; $display("FAIL fmt_op%0d: got v=%b i=%b data=%h want 1/0/%h", ops[k], resp_valid[0], resp_illegal[0], resp_data[0], exps[k]); end
      tick();
    end
  endtask

  task automatic test_store_abort;
    req_valid[0] = 1'b1; req_opcode = 6'd62; req_addr = 64'd20; req_wdata = 64'hDEAD_BEEF_0000_0001;
    tick();
    req_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (mem_write[0] !== 1'b0) begin errors++; $display("FAIL st_abort_write: got %b want 0", mem_write[0]); end
    tick();
    rst = 1'b0;
    checks++; if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || mem_address[0] !== 64'd0) begin errors++; $display("FAIL st_abort_state: got v=%b rdy=%b addr=%h want 0/1/0", resp_valid[0], req_ready[0], mem_address[0]); end
    tick();
    checks++; if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL st_abort_pulse: got %b want 0", resp_valid[0]); end
  endtask

  task automatic test_rst_wins;
    req_valid[0] = 1'b1; req_opcode = 6'd58; req_addr = 64'd7;
    rst = 1'b1;
    tick();
    rst = 1'b0; req_valid[0] = 1'b0;
    checks++; if (req_ready[0] !== 1'b1 || mem_read[0] !== 1'b0 || mem_address[0] !== 64'd0) begin errors++; $display("FAIL rst_wins: got rdy=%b r=%b addr=%h want 1/0/0", req_ready[0], mem_read[0], mem_address[0]); end
    tick();
    checks++; if (mem_read[0] !== 1'b0 || resp_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_wins_c2: got r=%b v=%b want 0/0", mem_read[0], resp_valid[0]); end
  endtask

  task automatic test_reset_mid_load;
    int pulses;
    req_valid[1] = 1'b1; req_opcode = 6'd58; req_addr = 64'd16;
    tick();
    req_valid[1] = 1'b0;
    checks++; if (mem_read[1] !== 1'b1) begin errors++; $display("FAIL midrst_c1: got %b want 1", mem_read[1]); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (mem_read[1] !== 1'b0 || resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin errors++; $display("FAIL midrst_after: got r=%b v=%b rdy=%b want 0/0/1", mem_read[1], resp_valid[1], req_ready[1]); end
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (resp_valid[1] === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_pulse: got %0d pulses want 0", pulses); end
    req_valid[1] = 1'b1; req_opcode = 6'd58; req_addr = 64'd24;
    mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    req_valid[1] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++; if (mem_read[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin errors++; $display("FAIL midrst_relaunch_c%0d: got r=%b v=%b want 1/0", k, mem_read[1], resp_valid[1]); end
      tick();
    end
    checks++; if (resp_valid[1] !== 1'b1 || resp_data[1] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL midrst_relaunch_resp: got v=%b data=%h want 1/0123456789abcdef", resp_valid[1], resp_data[1]); end
    tick();
  endtask

  task automatic test_back_to_back;
    int pulses;
    logic exp_v;
    logic exp_r;
    logic exp_rd;
    pulses = 0;
    mem_rdata = 64'h5555_AAAA_0F0F_F0F0;
    req_valid[2] = 1'b1; req_opcode = 6'd58; req_addr = 64'd40;
    for (int t = 0; t < 24; t++) begin
      exp_v  = (t < 16) && ((t % 4) == 3);
      exp_r  = (t >= 16) || ((t % 4) == 0);
      exp_rd = (t < 16) && (((t % 4) == 1) || ((t % 4) == 2));
      checks++; if (resp_valid[2] !== exp_v || req_ready[2] !== exp_r || mem_read[2] !== exp_rd || mem_write[2] !== 1'b0) begin errors++; $display("FAIL b2b_t%0d: got v=%b rdy=%b r=%b w=%b want %b/%b/%b/0", t, resp_valid[2], req_ready[2], mem_read[2], mem_write[2], exp_v, exp_r, exp_rd); end
      if (resp_valid[2] === 1'b1) begin
        pulses++;
        checks++; if (resp_data[2] !== 64'h5555_AAAA_0F0F_F0F0) begin errors++; $display("FAIL b2b_data_t%0d: got %h want 5555aaaa0f0ff0f0", t, resp_data[2]); end
        if (pulses == 4) req_valid[2] = 1'b0;
      end
      tick();
    end
    checks++; if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
  endtask

  initial begin
    rst = 1'b1;
    for (int u = 0; u < 3; u++) req_valid[u] = 1'b0;
    req_opcode = 6'd0; req_addr = 64'd0; req_wdata = 64'd0; mem_rdata = 64'd0;
    test_reset();
    test_lbz();
    test_store();
    test_lha();
    test_illegal();
    test_load_fmt();
    test_store_abort();
    test_rst_wins();
    test_reset_mid_load();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
